// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe controller: conditions three raw buttons and runs the game.
// Holds board, cursor and turn, and drives registered outputs to the VGA display stage.
module ttt_game_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_next,
    input  logic        btn_place,
    input  logic        btn_restart,
    output logic [17:0] board,
    output logic [3:0]  cursor,
    output logic        turn,
    output logic        game_over,
    output logic [1:0]  winner
);

    localparam int unsigned NUM_BTN = 3;
    localparam int unsigned NUM_SQ  = 9;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t               state;
    logic [NUM_BTN-1:0]   raw;
    logic [NUM_BTN-1:0]   pulse;
    logic                 next_p;
    logic                 place_p;
    logic                 restart_p;

    assign raw       = {btn_restart, btn_place, btn_next};
    assign next_p    = pulse[0];
    assign place_p   = pulse[1];
    assign restart_p = pulse[2];

    // Per-button synchroniser, debouncer and rising-edge pulse.
    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        logic             sync1;
        logic             sync2;
        logic             level;
        logic             pls;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                level <= 1'b0;
                pls   <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= raw[b];
                sync2 <= sync1;
                pls   <= 1'b0;
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    // Accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle.
                    level <= sync2;
                    pls   <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign pulse[b] = pls;
    end

    logic [1:0] sq [NUM_SQ];
    logic [NUM_SQ-1:0] occ;

    for (genvar g = 0; g < NUM_SQ; g++) begin : g_sq
        assign sq[g]  = board[2*g+1 : 2*g];
        assign occ[g] = |board[2*g+1 : 2*g];
    end

    function automatic logic line3(input logic [1:0] a, input logic [1:0] b,
                                   input logic [1:0] c);
        return (a != 2'b00) && (a == b) && (a == c);
    endfunction

    logic       win_c;
    logic       full_c;
    logic [1:0] cur_sq_c;

    always_comb begin
        win_c    = 1'b0;
        full_c   = &occ;
        cur_sq_c = sq[cursor];
        win_c    = line3(sq[0], sq[1], sq[2]) | line3(sq[3], sq[4], sq[5]) |
                   line3(sq[6], sq[7], sq[8]) | line3(sq[0], sq[3], sq[6]) |
                   line3(sq[1], sq[4], sq[7]) | line3(sq[2], sq[5], sq[8]) |
                   line3(sq[0], sq[4], sq[8]) | line3(sq[2], sq[4], sq[6]);
    end

    // Game FSM; restart wins over everything else arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PLAY;
            board     <= '0;
            cursor    <= '0;
            turn      <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'b00;
        end else if (restart_p) begin
            state     <= PLAY;
            board     <= '0;
            cursor    <= '0;
            turn      <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'b00;
        end else begin
            case (state)
                PLAY: begin
                    if (place_p) begin
                        if (cur_sq_c == 2'b00) begin
                            board[{cursor, 1'b0} +: 2] <= turn ? 2'b10 : 2'b01;
                            state <= CHECK;
                        end
                    end else if (next_p) begin
                        cursor <= (cursor == 4'd8) ? 4'd0 : cursor + 4'd1;
                    end
                end
                CHECK: begin
                    // A completed line outranks a full board.
                    if (win_c) begin
                        winner    <= turn ? 2'b10 : 2'b01;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (full_c) begin
                        winner    <= 2'b11;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        turn  <= ~turn;
                        state <= PLAY;
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl with a 4-cycle debounce.
// Move tables are replayed through raw button presses; corner cases are hand sequenced.
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        btn_next = 1'b0;
    logic        btn_place = 1'b0;
    logic        btn_restart = 1'b0;
    logic [17:0] board;
    logic [3:0]  cursor;
    logic        turn;
    logic        game_over;
    logic [1:0]  winner;

    int errors = 0;
    int checks = 0;
    int mcur = 0;

    typedef struct {
        int          op;     // 0 restart, 1 goto+place, 2 next press, 3 place press
        int          sq;
        logic [3:0]  cur;
        logic [17:0] brd;
        logic        trn;
        logic        go;
        logic [1:0]  win;
    } vec_t;

    vec_t vecs[$];

    ttt_game_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_next(btn_next), .btn_place(btn_place), .btn_restart(btn_restart),
        .board(board), .cursor(cursor), .turn(turn),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [17:0] b, input logic [3:0] c,
                             input logic t, input logic go, input logic [1:0] w);
        check({tag, " board"}, 32'(board), 32'(b));
        check({tag, " cursor"}, 32'(cursor), 32'(c));
        check({tag, " turn"}, 32'(turn), 32'(t));
        check({tag, " game_over"}, 32'(game_over), 32'(go));
        check({tag, " winner"}, 32'(winner), 32'(w));
    endtask

    task automatic press(input logic n, input logic p, input logic r);
        @(negedge clk);
        btn_next = n; btn_place = p; btn_restart = r;
        repeat (8) @(negedge clk);
        btn_next = 1'b0; btn_place = 1'b0; btn_restart = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic goto_sq(input int s);
        while (mcur != s) begin
            press(1'b1, 1'b0, 1'b0);
            mcur = (mcur == 8) ? 0 : mcur + 1;
        end
    endtask

    task automatic add(input int op, input int s, input logic [3:0] c, input logic [17:0] b,
                       input logic t, input logic go, input logic [1:0] w);
        vec_t v;
        v.op = op; v.sq = s; v.cur = c; v.brd = b; v.trn = t; v.go = go; v.win = w;
        vecs.push_back(v);
    endtask

    initial begin
        // Basic placement and occupied square.
        add(1, 0, 4'd0, 18'h00001, 1'b1, 1'b0, 2'b00);
        add(1, 1, 4'd1, 18'h00009, 1'b0, 1'b0, 2'b00);
        add(3, 1, 4'd1, 18'h00009, 1'b0, 1'b0, 2'b00);
        add(0, 0, 4'd0, 18'h00000, 1'b0, 1'b0, 2'b00);
        // RED row 0,1,2 with BLUE on 3,4, then frozen.
        add(1, 0, 4'd0, 18'h00001, 1'b1, 1'b0, 2'b00);
        add(1, 3, 4'd3, 18'h00081, 1'b0, 1'b0, 2'b00);
        add(1, 1, 4'd1, 18'h00085, 1'b1, 1'b0, 2'b00);
        add(1, 4, 4'd4, 18'h00285, 1'b0, 1'b0, 2'b00);
        add(1, 2, 4'd2, 18'h00295, 1'b0, 1'b1, 2'b01);
        add(2, 0, 4'd2, 18'h00295, 1'b0, 1'b1, 2'b01);
        add(3, 0, 4'd2, 18'h00295, 1'b0, 1'b1, 2'b01);
        add(0, 0, 4'd0, 18'h00000, 1'b0, 1'b0, 2'b00);
        // Draw: R{0,2,3,7,8} B{1,4,5,6}.
        add(1, 0, 4'd0, 18'h00001, 1'b1, 1'b0, 2'b00);
        add(1, 1, 4'd1, 18'h00009, 1'b0, 1'b0, 2'b00);
        add(1, 2, 4'd2, 18'h00019, 1'b1, 1'b0, 2'b00);
        add(1, 4, 4'd4, 18'h00219, 1'b0, 1'b0, 2'b00);
        add(1, 3, 4'd3, 18'h00259, 1'b1, 1'b0, 2'b00);
        add(1, 5, 4'd5, 18'h00A59, 1'b0, 1'b0, 2'b00);
        add(1, 7, 4'd7, 18'h04A59, 1'b1, 1'b0, 2'b00);
        add(1, 6, 4'd6, 18'h06A59, 1'b0, 1'b0, 2'b00);
        add(1, 8, 4'd8, 18'h16A59, 1'b0, 1'b1, 2'b11);
        add(0, 0, 4'd0, 18'h00000, 1'b0, 1'b0, 2'b00);
        // Ninth move completes column 2,5,8 for RED.
        add(1, 0, 4'd0, 18'h00001, 1'b1, 1'b0, 2'b00);
        add(1, 1, 4'd1, 18'h00009, 1'b0, 1'b0, 2'b00);
        add(1, 2, 4'd2, 18'h00019, 1'b1, 1'b0, 2'b00);
        add(1, 3, 4'd3, 18'h00099, 1'b0, 1'b0, 2'b00);
        add(1, 5, 4'd5, 18'h00499, 1'b1, 1'b0, 2'b00);
        add(1, 4, 4'd4, 18'h00699, 1'b0, 1'b0, 2'b00);
        add(1, 7, 4'd7, 18'h04699, 1'b1, 1'b0, 2'b00);
        add(1, 6, 4'd6, 18'h06699, 1'b0, 1'b0, 2'b00);
        add(1, 8, 4'd8, 18'h16699, 1'b0, 1'b1, 2'b01);
        add(0, 0, 4'd0, 18'h00000, 1'b0, 1'b0, 2'b00);
        // BLUE row 3,4,5.
        add(1, 0, 4'd0, 18'h00001, 1'b1, 1'b0, 2'b00);
        add(1, 3, 4'd3, 18'h00081, 1'b0, 1'b0, 2'b00);
        add(1, 1, 4'd1, 18'h00085, 1'b1, 1'b0, 2'b00);
        add(1, 4, 4'd4, 18'h00285, 1'b0, 1'b0, 2'b00);
        add(1, 8, 4'd8, 18'h10285, 1'b1, 1'b0, 2'b00);
        add(1, 5, 4'd5, 18'h10A85, 1'b1, 1'b1, 2'b10);
        add(0, 0, 4'd0, 18'h00000, 1'b0, 1'b0, 2'b00);

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset", 18'h0, 4'd0, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                0: press(1'b0, 1'b0, 1'b1);
                1: begin goto_sq(vecs[i].sq); press(1'b0, 1'b1, 1'b0); end
                2: press(1'b1, 1'b0, 1'b0);
                default: press(1'b0, 1'b1, 1'b0);
            endcase
            mcur = int'(vecs[i].cur);
            check_all($sformatf("row%0d", i), vecs[i].brd, vecs[i].cur, vecs[i].trn,
                      vecs[i].go, vecs[i].win);
        end

        // Press-to-action latency: 2 sync + 4 debounce + 1.
        @(negedge clk);
        btn_next = 1'b1;
        repeat (6) @(negedge clk);
        check("latency_early cursor", 32'(cursor), 32'd0);
        @(negedge clk);
        check("latency_edge cursor", 32'(cursor), 32'd1);
        repeat (13) @(negedge clk);
        check("long_hold cursor", 32'(cursor), 32'd1);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        check("release cursor", 32'(cursor), 32'd1);

        // 3-cycle glitch is rejected.
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch cursor", 32'(cursor), 32'd1);

        // Nine presses wrap the cursor back to 0.
        press(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) press(1'b1, 1'b0, 1'b0);
        check("wrap8 cursor", 32'(cursor), 32'd8);
        press(1'b1, 1'b0, 1'b0);
        check("wrap0 cursor", 32'(cursor), 32'd0);
        mcur = 0;

        // Restart and place in the same cycle: restart wins.
        goto_sq(3);
        press(1'b0, 1'b1, 1'b0);
        check_all("pre_restart", 18'h00040, 4'd3, 1'b1, 1'b0, 2'b00);
        press(1'b0, 1'b1, 1'b1);
        check_all("restart_place", 18'h0, 4'd0, 1'b0, 1'b0, 2'b00);
        mcur = 0;

        // Asynchronous reset while in CHECK.
        @(negedge clk);
        btn_place = 1'b1;
        repeat (7) @(negedge clk);
        check("place_n1 board", 32'(board), 32'h1);
        check("place_n1 turn", 32'(turn), 32'd0);
        btn_place = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 18'h0, 4'd0, 1'b0, 1'b0, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_all("post_reset", 18'h0, 4'd0, 1'b0, 1'b0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
